// File: rtl/spi_mem_arbiter.sv
// SPI memory arbiter: fetch and data ports share one SPI bus.
// Flash on addr[23]=0, RAM on addr[23]=1; mode-0 framing.
module spi_mem_arbiter #(
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [23:0] f_addr,
  output logic        f_ready,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [23:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_flash_n,
  output logic        spi_cs_ram_n,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_d_q, gnt_d_d;
  logic        last_d_q, last_d_d;
  logic        we_q, we_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [5:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic [63:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic        cs_f_q, cs_f_d;
  logic        cs_r_q, cs_r_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        f_ready_q, f_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        any_req;
  logic        pick_d;
  logic [23:0] sel_addr;
  logic        sel_we;
  logic [2:0]  sel_bytes;
  logic [31:0] sel_wdata;
  logic [63:0] frame;
  logic        flash_wr;
  logic [5:0]  last_bit;
  logic [31:0] rx_word;

  // Arbitration and request decode for the port about to be granted
  always_comb begin
    any_req  = f_req | d_req;
    pick_d   = d_req & (~f_req | ~last_d_q);
    sel_addr = pick_d ? d_addr : f_addr;
    sel_we   = pick_d & d_we;
    flash_wr = sel_we & ~sel_addr[23];
    sel_bytes = 3'd4;
    if (pick_d) begin
      unique case (d_size)
        2'd0:    sel_bytes = 3'd1;
        2'd1:    sel_bytes = 3'd2;
        default: sel_bytes = 3'd4;
      endcase
    end
    sel_wdata = '0;
    if (sel_we) begin
      sel_wdata = {d_wdata[7:0], d_wdata[15:8],
                   d_wdata[23:16], d_wdata[31:24]};
    end
    frame = {sel_we ? CMD_WRITE : CMD_READ,
             1'b0, sel_addr[22:0], sel_wdata};
  end

  // Frame length and byte reordering of the received data
  always_comb begin
    last_bit = 6'd31 + {nbytes_q, 3'b000};
    unique case (nbytes_q)
      3'd1:    rx_word = {24'd0, rx_q[7:0]};
      3'd2:    rx_word = {16'd0, rx_q[7:0], rx_q[15:8]};
      default: rx_word = {rx_q[7:0], rx_q[15:8],
                          rx_q[23:16], rx_q[31:24]};
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_d_q   <= 1'b0;
      last_d_q  <= 1'b0;
      we_q      <= 1'b0;
      nbytes_q  <= 3'd4;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      cs_f_q    <= 1'b1;
      cs_r_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      f_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_d_q   <= gnt_d_d;
      last_d_q  <= last_d_d;
      we_q      <= we_d;
      nbytes_q  <= nbytes_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cs_f_q    <= cs_f_d;
      cs_r_q    <= cs_r_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      f_ready_q <= f_ready_d;
      d_ready_q <= d_ready_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = flash_wr ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        if (phase_q && (bit_q == last_bit)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus, shift register and port response updates
  always_comb begin
    gnt_d_d   = gnt_d_q;
    last_d_d  = last_d_q;
    we_d      = we_q;
    nbytes_d  = nbytes_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cs_f_d    = cs_f_q;
    cs_r_d    = cs_r_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    f_ready_d = 1'b0;
    d_ready_d = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d_d  = pick_d;
          last_d_d = pick_d;
          we_d     = sel_we;
          nbytes_d = sel_bytes;
          if (flash_wr) begin
            d_ready_d = 1'b1;
            d_rdata_d = '0;
          end else begin
            cs_f_d  = sel_addr[23];
            cs_r_d  = ~sel_addr[23];
            sclk_d  = 1'b0;
            mosi_d  = frame[63];
            tx_d    = {frame[62:0], 1'b0};
            rx_d    = '0;
            bit_d   = '0;
            phase_d = 1'b0;
          end
        end
      end
      S_XFER: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[30:0], spi_miso};
        end else if (bit_q == last_bit) begin
          phase_d = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = 1'b0;
          cs_f_d  = 1'b1;
          cs_r_d  = 1'b1;
          if (gnt_d_q) begin
            d_ready_d = 1'b1;
            d_rdata_d = we_q ? 32'd0 : rx_word;
          end else begin
            f_ready_d = 1'b1;
            f_rdata_d = rx_word;
          end
        end else begin
          bit_d   = bit_q + 6'd1;
          phase_d = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = tx_q[63];
          tx_d    = {tx_q[62:0], 1'b0};
        end
      end
      default: begin
      end
    endcase
  end

  // Registered outputs
  always_comb begin
    f_ready        = f_ready_q;
    f_rdata        = f_rdata_q;
    d_ready        = d_ready_q;
    d_rdata        = d_rdata_q;
    spi_sclk       = sclk_q;
    spi_mosi       = mosi_q;
    spi_cs_flash_n = cs_f_q;
    spi_cs_ram_n   = cs_r_q;
    busy           = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: SPI memory slave, per-port
// scoreboard, directed scenarios and concurrent random traffic.
module tb_spi_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        f_req = 1'b0;
  logic [23:0] f_addr = '0;
  logic        f_ready;
  logic [31:0] f_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = '0;
  logic [23:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;
  logic        spi_cs_flash_n;
  logic        spi_cs_ram_n;
  logic        busy;

  spi_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr),
    .f_ready(f_ready), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_cs_flash_n(spi_cs_flash_n),
    .spi_cs_ram_n(spi_cs_ram_n),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- memory models ----------------
  logic [7:0] fl_over[int];
  logic [7:0] ref_ram[int];
  logic [7:0] sl_ram[int];

  function automatic logic [7:0] fl_byte(input logic [22:0] a);
    if (fl_over.exists(int'(a))) return fl_over[int'(a)];
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A ^ {1'b0, a[22:16]};
  endfunction

  function automatic logic [7:0] ram_init(input logic [22:0] a);
    return ~a[7:0] ^ a[14:7];
  endfunction

  function automatic logic [7:0] ref_get(input logic [23:0] a);
    int k;
    k = int'(a[22:0]);
    if (!a[23]) return fl_byte(a[22:0]);
    if (ref_ram.exists(k)) return ref_ram[k];
    return ram_init(a[22:0]);
  endfunction

  function automatic logic [7:0] sl_get(input logic [22:0] a);
    if (sl_ram.exists(int'(a))) return sl_ram[int'(a)];
    return ram_init(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [23:0] addr,
                                           input int nb);
    logic [31:0] v;
    logic [23:0] a;
    v = '0;
    for (int i = 0; i < nb; i++) begin
      a = addr + 24'(i);
      v[8*i +: 8] = ref_get(a);
    end
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          chk;
    logic [31:0] val;
  } exp_t;
  exp_t fq[$];
  exp_t dq[$];
  int f_seen = 0;
  int d_seen = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (f_ready === 1'b1) begin
        f_seen++;
        if (fq.size() == 0) begin
          check("f_unexpected_ready", 1, 0);
        end else begin
          e = fq.pop_front();
          check("f_rdata", f_rdata, e.val);
        end
      end
      if (d_ready === 1'b1) begin
        d_seen++;
        if (dq.size() == 0) begin
          check("d_unexpected_ready", 1, 0);
        end else begin
          e = dq.pop_front();
          if (e.chk) check("d_rdata", d_rdata, e.val);
        end
      end
    end
  end

  // ---------------- SPI slave ----------------
  logic [7:0]  last_rx[$];
  logic [7:0]  s_rx[$];
  bit          last_ram = 0;
  int          last_low = 0;
  int          start_cyc_f = 0;
  int          frames = 0;
  bit          abort_ok = 0;

  initial begin : slave
    bit          act, prev_act, prev_sclk, s_ram;
    int          s_cnt, s_low, idx;
    logic [7:0]  s_sh, s_op, b;
    logic [23:0] s_addr, a;
    prev_act = 0; prev_sclk = 0; s_ram = 0;
    s_cnt = 0; s_low = 0; s_sh = 0; s_op = 0; s_addr = 0;
    forever begin
      @(negedge clk);
      act = !spi_cs_flash_n || !spi_cs_ram_n;
      if (!spi_cs_flash_n && !spi_cs_ram_n)
        check("both_cs_low", 1, 0);
      if (act && !prev_act) begin
        s_cnt = 0; s_low = 0; s_op = 0; s_addr = 0;
        s_rx.delete();
        s_ram = !spi_cs_ram_n;
        frames++;
        if (!s_ram) start_cyc_f = cyc;
      end
      if (act) begin
        s_low++;
        if (spi_sclk && !prev_sclk) begin
          s_sh = {s_sh[6:0], spi_mosi};
          s_cnt++;
          if (s_cnt % 8 == 0) s_rx.push_back(s_sh);
          if (s_cnt == 32) begin
            s_op = s_rx[0];
            s_addr = {s_rx[1], s_rx[2], s_rx[3]};
          end
        end
        if (s_cnt >= 32 && s_op == 8'h03) begin
          idx = s_cnt - 32;
          a = s_addr + 24'(idx / 8);
          b = s_ram ? sl_get(a[22:0]) : fl_byte(a[22:0]);
          spi_miso = b[7 - (idx % 8)];
        end else begin
          spi_miso = 1'b0;
        end
      end else begin
        spi_miso = 1'b0;
        check("mosi_idle", spi_mosi, 0);
      end
      if (!act && prev_act) begin
        last_rx = s_rx;
        last_ram = s_ram;
        last_low = s_low;
        if (!abort_ok) begin
          check("frame_len",
                (s_cnt == 40 || s_cnt == 48 || s_cnt == 64) &&
                (s_cnt == 8 * s_rx.size()), 1);
          check("frame_cs_cycles", s_low, 2 * s_cnt);
          check("frame_op", (s_op == 8'h03) ||
                (s_op == 8'h02 && s_ram), 1);
          check("frame_addr23", s_addr[23], 0);
          if (s_op == 8'h02 && s_ram) begin
            for (int i = 4; i < s_rx.size(); i++) begin
              a = s_addr + 24'(i - 4);
              sl_ram[int'(a[22:0])] = s_rx[i];
            end
          end
        end
      end
      prev_act = act;
      prev_sclk = spi_sclk;
    end
  end

  function automatic logic [63:0] head(input int k);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < k && i < last_rx.size(); i++)
      v = (v << 8) | 64'(last_rx[i]);
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic issue_f(input logic [23:0] addr,
                         output int lat, output int rc);
    exp_t e;
    int c0;
    bit got;
    e.chk = 1;
    e.val = ref_read(addr, 4);
    fq.push_back(e);
    @(negedge clk);
    f_addr = addr;
    f_req = 1'b1;
    c0 = cyc;
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (f_ready === 1'b1) got = 1;
    end
    if (!got) check("f_timeout", 0, 1);
    f_req = 1'b0;
    rc = cyc;
    lat = cyc - c0;
  endtask

  task automatic issue_d(input logic we, input logic [1:0] sz,
                         input logic [23:0] addr,
                         input logic [31:0] wd,
                         output int lat, output int rc);
    exp_t e;
    int c0, nb;
    bit got;
    logic [23:0] a;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.chk = !we;
    e.val = we ? 32'd0 : ref_read(addr, nb);
    if (we && addr[23]) begin
      for (int i = 0; i < nb; i++) begin
        a = addr + 24'(i);
        ref_ram[int'(a[22:0])] = wd[8*i +: 8];
      end
    end
    dq.push_back(e);
    @(negedge clk);
    d_we = we;
    d_size = sz;
    d_addr = addr;
    d_wdata = wd;
    d_req = 1'b1;
    c0 = cyc;
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (d_ready === 1'b1) got = 1;
    end
    if (!got) check("d_timeout", 0, 1);
    d_req = 1'b0;
    rc = cyc;
    lat = cyc - c0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    f_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int lat, rc, lat2, rc2, fr0, seen;
    logic [23:0] a;
    logic [1:0]  sz;
    bit          we;

    repeat (3) @(negedge clk);
    check("rst_cs_flash", spi_cs_flash_n, 1);
    check("rst_cs_ram", spi_cs_ram_n, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_ready", {f_ready, d_ready}, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", {f_rdata, d_rdata}, 0);
    reset = 1'b0;

    fl_over[32'h100] = 8'h11;
    fl_over[32'h101] = 8'h22;
    fl_over[32'h102] = 8'h33;
    fl_over[32'h103] = 8'h44;
    issue_f(24'h000100, lat, rc);
    @(negedge clk);
    check("fetch_lat", lat, 129);
    check("fetch_cs_low", last_low, 128);
    check("fetch_flash_sel", last_ram, 0);
    check("fetch_mosi_hdr", head(4), 64'h03000100);
    check("fetch_word", f_rdata, 32'h44332211);

    issue_d(1'b1, 2'd0, 24'h800010, 32'h000000A5, lat, rc);
    @(negedge clk);
    check("wrb_lat", lat, 81);
    check("wrb_cs_low", last_low, 80);
    check("wrb_ram_sel", last_ram, 1);
    check("wrb_mosi", head(5), 64'h02000010A5);

    ref_ram[32'h20] = 8'hBE; sl_ram[32'h20] = 8'hBE;
    ref_ram[32'h21] = 8'hEF; sl_ram[32'h21] = 8'hEF;
    issue_d(1'b0, 2'd1, 24'h800020, 32'hFFFFFFFF, lat, rc);
    @(negedge clk);
    check("half_lat", lat, 97);
    check("half_rdata", d_rdata, 32'h0000EFBE);

    issue_d(1'b0, 2'd0, 24'h800010, 32'h0, lat, rc);
    check("byte_lat", lat, 81);

    fr0 = frames;
    issue_d(1'b1, 2'd2, 24'h000004, $urandom, lat, rc);
    repeat (3) @(negedge clk);
    check("flash_wr_lat", lat, 1);
    check("flash_wr_no_spi", frames, fr0);

    do_reset();
    fork
      issue_f(24'h001234, lat, rc);
      issue_d(1'b0, 2'd2, 24'h800040, 32'h0, lat2, rc2);
    join
    check("tie_data_first", rc2 < rc, 1);
    check("tie_fetch_grant", start_cyc_f - rc2, 2);
    check("tie_data_lat", lat2, 129);

    do_reset();
    @(negedge clk);
    f_addr = 24'h000200;
    f_req = 1'b1;
    repeat (40) @(negedge clk);
    abort_ok = 1;
    reset = 1'b1;
    f_req = 1'b0;
    seen = f_seen;
    @(negedge clk);
    reset = 1'b0;
    check("abort_cs", {spi_cs_flash_n, spi_cs_ram_n}, 2'b11);
    check("abort_busy", busy, 0);
    repeat (150) @(negedge clk);
    check("abort_no_ready", f_seen, seen);
    abort_ok = 0;
    issue_f(24'h000200, lat, rc);
    check("refetch_lat", lat, 129);

    fork
      begin
        int fl, fr;
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 5)) @(negedge clk);
          issue_f(24'($urandom_range(0, 32'h7FFF00)), fl, fr);
        end
      end
      begin
        int dl, dr;
        logic [23:0] da;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 5)) @(negedge clk);
          if ($urandom_range(0, 2) != 0)
            da = 24'h800000 | 24'($urandom_range(0, 63));
          else
            da = 24'($urandom_range(0, 32'h7FFF00));
          issue_d(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  da, $urandom, dl, dr);
        end
      end
    join

    for (int i = 0; i < 8; i++) begin
      a = 24'h800000 | 24'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      we = 1'b0;
      issue_d(we, sz, a, 32'h0, lat, rc);
      check("rand_rd_lat", lat,
            (sz == 2'd0) ? 81 : (sz == 2'd1) ? 97 : 129);
    end

    repeat (5) @(negedge clk);
    check("fq_drained", fq.size(), 0);
    check("dq_drained", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
